// File: rtl/core_pkg.sv
// Phase codes and shared constants for the multicycle core; imported by the
// sequencer and by the fetch, decode, register, ALU and memory blocks.
package core_pkg;

    localparam int STATE_W_DEF = 4;

    typedef enum logic [3:0] {
        PH_IF    = 4'd0,
        PH_ID    = 4'd1,
        PH_EX    = 4'd2,
        PH_MEM   = 4'd3,
        PH_WB    = 4'd4,
        PH_SUMPC = 4'd8,
        PH_FIM   = 4'd9
    } phase_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Per-phase wait counter: cleared on phase change, counts while enabled and
// flags terminal count against a limit chosen at runtime by the sequencer.
module seq_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle core phase sequencer with programmable EX/WB waits, memory ack
// timeout and retired counter. Optional single-step hold: MULTICYCLE_SEQUENCER_STEP_EN.
module multicycle_sequencer
    import core_pkg::*;
#(
    parameter int STATE_W     = STATE_W_DEF,
    parameter int EX_CYCLES   = 3,
    parameter int WB_CYCLES   = 3,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic [31:0]        instr,
    input  logic               is_mem,
    input  logic               imem_ack,
    input  logic               dmem_ack,
`ifdef MULTICYCLE_SEQUENCER_STEP_EN
    input  logic               step,
`endif
    output logic [STATE_W-1:0] estado,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               wb_strobe,
    output logic               pc_en,
    output logic               halted,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   retired
);

    localparam int WCNT_W = $clog2(max3(EX_CYCLES, WB_CYCLES, ACK_TIMEOUT) + 1);
    localparam logic [WCNT_W-1:0] EX_LIM  = WCNT_W'(EX_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WB_LIM  = WCNT_W'(WB_CYCLES - 1);
    localparam logic [WCNT_W-1:0] ACK_LIM = WCNT_W'(ACK_TIMEOUT - 1);

`ifdef MULTICYCLE_SEQUENCER_STEP_EN
    localparam logic STEP_HOLD = 1'b1;
    logic step_s;
    assign step_s = step;
`else
    localparam logic STEP_HOLD = 1'b0;
    logic step_s;
    assign step_s = 1'b0;
`endif

    phase_e            state_q, state_d;
    logic              terr_q, terr_d;
    logic              hold_q, hold_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [WCNT_W-1:0] wcnt_s;
    logic [WCNT_W-1:0] lim_s;
    logic              tc_s;
    logic              clr_s;
    logic              en_s;

    // Terminal count limit for whichever phase is currently waiting.
    always_comb begin
        lim_s = ACK_LIM;
        case (state_q)
            PH_EX:   lim_s = EX_LIM;
            PH_WB:   lim_s = WB_LIM;
            default: lim_s = ACK_LIM;
        endcase
    end

    // The counter does not run while holding for a step or while halted.
    assign clr_s = (state_d != state_q);
    assign en_s  = !hold_q && (state_q != PH_FIM);

    seq_wait_counter #(
        .W(WCNT_W)
    ) u_wait (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (clr_s),
        .en_i    (en_s),
        .limit_i (lim_s),
        .cnt_o   (wcnt_s),
        .tc_o    (tc_s)
    );

    // Phase transitions, sticky timeout flag, retired count and step hold.
    always_comb begin
        state_d = state_q;
        terr_d  = terr_q;
        ret_d   = ret_q;
        hold_d  = hold_q;
        case (state_q)
            PH_IF: begin
                if (hold_q) begin
                    hold_d = !step_s;
                end else if (imem_ack) begin
                    state_d = PH_ID;
                end else if (tc_s) begin
                    state_d = PH_FIM;
                    terr_d  = 1'b1;
                end else begin
                    state_d = PH_IF;
                end
            end
            PH_ID: begin
                if (instr == 32'd0) begin
                    state_d = PH_FIM;
                end else begin
                    state_d = PH_EX;
                end
            end
            PH_EX: begin
                if (tc_s) begin
                    state_d = PH_MEM;
                end else begin
                    state_d = PH_EX;
                end
            end
            PH_MEM: begin
                if (!is_mem || dmem_ack) begin
                    state_d = PH_WB;
                end else if (tc_s) begin
                    state_d = PH_FIM;
                    terr_d  = 1'b1;
                end else begin
                    state_d = PH_MEM;
                end
            end
            PH_WB: begin
                if (tc_s) begin
                    state_d = PH_SUMPC;
                end else begin
                    state_d = PH_WB;
                end
            end
            PH_SUMPC: begin
                state_d = PH_IF;
                ret_d   = ret_q + CNT_W'(1);
                hold_d  = STEP_HOLD;
            end
            PH_FIM: begin
                if (restart) begin
                    state_d = PH_IF;
                    terr_d  = 1'b0;
                end else begin
                    state_d = PH_FIM;
                end
            end
            default: begin
                state_d = PH_FIM;
            end
        endcase
    end

    // State, flag and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PH_IF;
            terr_q  <= 1'b0;
            hold_q  <= 1'b0;
            ret_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            terr_q  <= terr_d;
            hold_q  <= hold_d;
            ret_q   <= ret_d;
        end
    end

    // Strobes decode registered state only; gating by rst kills them the instant reset falls.
    always_comb begin
        estado    = STATE_W'(state_q);
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        wb_strobe = 1'b0;
        pc_en     = 1'b0;
        halted    = 1'b0;
        if (rst) begin
            imem_req  = (state_q == PH_IF) && !hold_q;
            dmem_req  = (state_q == PH_MEM) && is_mem;
            wb_strobe = (state_q == PH_WB) && (wcnt_s == {WCNT_W{1'b0}});
            pc_en     = (state_q == PH_SUMPC);
            halted    = (state_q == PH_FIM);
        end else begin
            imem_req  = 1'b0;
        end
    end

    assign timeout_err = terr_q;
    assign retired     = ret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer (CNT_W=4): per-instruction phase schedule
// model with a negedge compare process plus literal spot checks.
module tb_multicycle_sequencer;

    localparam int ACK_TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        restart = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        is_mem = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  estado;
    logic        imem_req, dmem_req, wb_strobe, pc_en, halted, timeout_err;
    logic [3:0]  retired;

    multicycle_sequencer #(
        .STATE_W(4), .EX_CYCLES(3), .WB_CYCLES(3), .ACK_TIMEOUT(ACK_TO), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .instr(instr), .is_mem(is_mem),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
`ifdef MULTICYCLE_SEQUENCER_STEP_EN
        .step(step),
`endif
        .estado(estado), .imem_req(imem_req), .dmem_req(dmem_req),
        .wb_strobe(wb_strobe), .pc_en(pc_en), .halted(halted),
        .timeout_err(timeout_err), .retired(retired)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [13:0] exp_q[$];
    logic        terr_m = 1'b0;
    logic [3:0]  ret_m = 4'd0;
    logic        hold_m = 1'b0;
    logic        ack_tie = 1'b0;
    logic        mon_en = 1'b0;
    int          cnt_ireq, cnt_dreq, cnt_wb, cnt_pc, tr_n;
    int          trace [16];

    // Per-cycle compare against the schedule, plus scenario monitors.
    always @(negedge clk) begin
        logic [13:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {estado, imem_req, dmem_req, wb_strobe, pc_en, halted, timeout_err, retired};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle t=%0t: got estado=%0d req/strb/halt=%b terr=%b ret=%0d, need estado=%0d req/strb/halt=%b terr=%b ret=%0d",
                         $time, a[13:10], a[9:5], a[4], a[3:0], e[13:10], e[9:5], e[4], e[3:0]);
            end
        end
        if (mon_en) begin
            cnt_ireq += int'(imem_req);
            cnt_dreq += int'(dmem_req);
            cnt_wb   += int'(wb_strobe);
            cnt_pc   += int'(pc_en);
            if (tr_n < 16) trace[tr_n] = int'(estado);
            tr_n++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, need %0d", name, act, req);
        end
    endtask

    task automatic mon_start();
        cnt_ireq = 0; cnt_dreq = 0; cnt_wb = 0; cnt_pc = 0; tr_n = 0;
        mon_en = 1'b1;
    endtask

    // One cycle: expected outputs {ireq,dreq,wb,pc,halt}, then advance to just after the edge.
    task automatic cyc(input logic [3:0] e, input logic [4:0] o);
        exp_q.push_back({e, o, terr_m, ret_m});
        @(posedge clk);
        #1;
    endtask

    // One instruction from IF; ia/da are ack delays in cycles (>= ACK_TO means never).
    task automatic run_instr(input logic [31:0] w, input int ia, input logic m,
                             input int da, input logic ab);
        if (hold_m) begin
            for (int i = 0; i < 3; i++) begin
                step = (i == 2);
                cyc(4'd0, 5'b00000);
            end
            step = 1'b0;
            hold_m = 1'b0;
        end
        instr = w;
        is_mem = m;
        for (int i = 0; i < ACK_TO; i++) begin
            imem_ack = ack_tie | (i == ia);
            cyc(4'd0, 5'b10000);
            if (i == ia) break;
        end
        imem_ack = ack_tie;
        if (ia >= ACK_TO) begin
            terr_m = 1'b1;
            return;
        end
        cyc(4'd1, 5'b00000);
        if (w == 32'd0) return;
        repeat (3) cyc(4'd2, 5'b00000);
        if (!m) begin
            cyc(4'd3, 5'b00000);
        end else begin
            for (int i = 0; i < ACK_TO; i++) begin
                dmem_ack = ack_tie | (i == da);
                cyc(4'd3, 5'b01000);
                if (i == da) break;
            end
            dmem_ack = ack_tie;
            if (da >= ACK_TO) begin
                terr_m = 1'b1;
                return;
            end
        end
        cyc(4'd4, 5'b00100);
        if (ab) begin
            #2;
            rst = 1'b0;
            #1;
            chk("rst_estado", 32'(estado), 32'd0);
            chk("rst_strobes", 32'({imem_req, dmem_req, wb_strobe, pc_en, halted}), 32'd0);
            chk("rst_retired", 32'(retired), 32'd0);
            ret_m = 4'd0;
            terr_m = 1'b0;
            hold_m = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b1;
            return;
        end
        repeat (2) cyc(4'd4, 5'b00000);
        cyc(4'd8, 5'b00010);
        ret_m = ret_m + 4'd1;
`ifdef MULTICYCLE_SEQUENCER_STEP_EN
        hold_m = 1'b1;
`endif
    endtask

    task automatic fim(input int n);
        for (int i = 0; i < n; i++) begin
            restart = (i == n - 1);
            cyc(4'd9, 5'b00001);
        end
        restart = 1'b0;
        terr_m = 1'b0;
    endtask

    localparam logic [31:0] ADD = 32'h0020_8033;
    localparam logic [31:0] LW  = 32'h0000_A083;

    initial begin
        int exp_tr [10];
        exp_tr = '{0, 1, 2, 2, 2, 3, 4, 4, 4, 8};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_estado", 32'(estado), 32'd0);
        chk("reset_strobes", 32'({imem_req, dmem_req, wb_strobe, pc_en, halted}), 32'd0);
        chk("reset_terr_ret", 32'({timeout_err, retired}), 32'd0);
        rst = 1'b1;

        // Zero-wait add with acks tied high: the legacy 10-cycle sequence.
        ack_tie = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        mon_start();
        run_instr(ADD, 0, 1'b0, 0, 1'b0);
        mon_en = 1'b0;
        for (int i = 0; i < 10; i++) chk("trace_estado", 32'(trace[i]), 32'(exp_tr[i]));
        chk("trace_len", 32'(tr_n), 32'd10);
        chk("add_pc_pulses", 32'(cnt_pc), 32'd1);
        chk("add_retired", 32'(retired), 32'd1);
        chk("add_next_if", 32'(estado), 32'd0);
        ack_tie = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        // Load with dmem_ack on the fifth MEM cycle.
        mon_start();
        run_instr(LW, 0, 1'b1, 4, 1'b0);
        mon_en = 1'b0;
        chk("load_dreq_cycles", 32'(cnt_dreq), 32'd5);
        chk("load_wb_pulses", 32'(cnt_wb), 32'd1);
        chk("load_retired", 32'(retired), 32'd2);

        // restart outside FIM has no effect.
        restart = 1'b1;
        run_instr(ADD, 2, 1'b0, 0, 1'b0);
        restart = 1'b0;

        // imem_ack never comes: abort after 15 IF cycles, then restart.
        mon_start();
        run_instr(ADD, 99, 1'b0, 0, 1'b0);
        mon_en = 1'b0;
        chk("to_ireq_cycles", 32'(cnt_ireq), 32'd15);
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_terr", 32'(timeout_err), 32'd1);
        fim(3);
        chk("restart_estado", 32'(estado), 32'd0);
        chk("restart_terr", 32'(timeout_err), 32'd0);

        // Halt instruction.
        mon_start();
        run_instr(32'd0, 1, 1'b0, 0, 1'b0);
        mon_en = 1'b0;
        chk("halt_wb", 32'(cnt_wb), 32'd0);
        chk("halt_pc", 32'(cnt_pc), 32'd0);
        chk("halt_retired", 32'(retired), 32'd3);
        chk("halt_terr", 32'(timeout_err), 32'd0);
        fim(2);

        // dmem_ack never comes.
        run_instr(LW, 1, 1'b1, 99, 1'b0);
        chk("dto_terr", 32'(timeout_err), 32'd1);
        fim(1);

        // Reset during WB cycle 2, then 17 instructions wrap the 4-bit counter to 1.
        run_instr(ADD, 1, 1'b0, 0, 1'b1);
        for (int k = 0; k < 17; k++) begin
            run_instr(ADD + 32'(k), (k == 7) ? 14 : (k % 4), k[0], k % 3, 1'b0);
        end
        chk("wrap_retired", 32'(retired), 32'd1);
        cyc(4'd0, hold_m ? 5'b00000 : 5'b10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised successor to the fixed multicycle core controller.
- Sequences the per-instruction phases IF, ID, EX, MEM, WB, SUMPC and FIM.
- Replaces hard-coded delay states with programmable wait counters, and adds ready/ack handshakes to instruction and data memory with a timeout.
- Adds a retired-instruction counter; sits at core top, driving the phase bus shared by fetch, decode, register, ALU and memory blocks.

Parameters:
- STATE_W, 4, width of phase bus estado.
- EX_CYCLES, 3, cycles spent in EX (≥1).
- WB_CYCLES, 3, cycles spent in WB (≥1).
- ACK_TIMEOUT, 15, max cycles waiting for imem_ack/dmem_ack before abort (≥1).
- CNT_W, 16, width of retired counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- restart  in  1  pulse; leaves FIM.
- instr  in  32  current instruction word (zero = halt).
- is_mem  in  1  decoded load/store, valid from ID onward.
- imem_ack  in  1  instruction memory data valid.
- dmem_ack  in  1  data memory access complete.
- estado  out  STATE_W  current phase code.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data access request.
- wb_strobe  out  1  one-cycle register write strobe.
- pc_en  out  1  one-cycle PC update strobe.
- halted  out  1  high in FIM.
- timeout_err  out  1  sticky handshake-timeout flag.
- retired  out  CNT_W  completed-instruction count.

Behaviour:
- Phase codes: IF=0, ID=1, EX=2, MEM=3, WB=4, SUMPC=8, FIM=9. Unused codes go to FIM.
- Reset (rst low, async): estado=IF, wait counter=0, retired=0, timeout_err=0, all strobes/reqs=0, halted=0.
- Internal wait counter wcnt, width clog2(max(EX_CYCLES,WB_CYCLES,ACK_TIMEOUT)+1).
  - Cleared on every phase change.
  - Incremented each cycle within a phase.
- IF:
  - imem_req=1 combinationally while in IF.
  - On imem_ack=1 → ID.
  - If wcnt reaches ACK_TIMEOUT-1 without ack → FIM, timeout_err=1.
  - Ack on the timeout cycle wins (→ ID).
- ID: exactly 1 cycle. instr==0 → FIM (timeout_err unchanged); else → EX.
- EX: exactly EX_CYCLES cycles, then → MEM.
- MEM:
  - is_mem=0: 1 cycle, dmem_req=0, → WB.
  - is_mem=1: dmem_req=1 until dmem_ack; ack → WB. Timeout is the same rule as IF.
- WB: WB_CYCLES cycles; wb_strobe=1 on the first WB cycle only; then → SUMPC.
- SUMPC: 1 cycle; pc_en=1; retired increments, wrapping at 2^CNT_W; → IF.
- FIM:
  - halted=1; stays until restart=1.
  - restart → IF, clears timeout_err; retired is kept.
  - restart outside FIM is ignored.
- Strobes (wb_strobe, pc_en, dmem_req, imem_req) are decoded from registered state and wcnt; no glitch paths from ack inputs except req deassertion on the following cycle.
- Instruction latency with zero-wait acks, non-mem: 1+1+EX_CYCLES+1+WB_CYCLES+1 cycles (defaults: 10, matching the legacy sequence).
- Reset mid-phase aborts immediately; no strobe fires after rst falls.

Optional Feature:
- Macro: MULTICYCLE_SEQUENCER_STEP_EN.
- Defined: adds input step (1 bit). After SUMPC the FSM holds in IF with imem_req=0 until step=1 is sampled, then fetches normally. The timeout counter does not run while holding.
- Undefined: no step port; SUMPC → IF fetches immediately.

Decomposition:
- Shared package core_pkg: phase code localparams (IF, ID, EX, MEM, WB, SUMPC, FIM) and STATE_W default. The fetch, decode, register, ALU and memory blocks import the same codes.
- One natural sub-module: seq_wait_counter (clear, enable, terminal-count compare with runtime limit select). It is shared by the EX, WB and timeout uses.

Test Plan:
- Defaults, imem_ack and dmem_ack tied high, add-type instr, is_mem=0: estado sequence 0,1,2,2,2,3,4,4,4,8,0; pc_en one pulse; retired=1.
- Load (is_mem=1), dmem_ack delayed 4 cycles: dmem_req high 5 cycles in MEM; wb_strobe exactly once; retired=1.
- imem_ack never asserted, ACK_TIMEOUT=15: FIM after 15 IF cycles; timeout_err=1, halted=1. Then restart pulse: estado=IF, timeout_err=0.
- instr=0 fetched: ID → FIM; no wb_strobe, no pc_en; retired unchanged.
- rst low during WB cycle 2: estado=0 and strobes 0 asynchronously; retired=0. Release: fetch restarts.
- CNT_W=4, run 17 instructions: retired wraps to 1. With MULTICYCLE_SEQUENCER_STEP_EN: no second fetch until step pulse.
